// File: rtl/fwnoc_host_tx.sv
// fwnoc_host_tx: host-side NoC transmitter feeding a router's host ingress port.
// Turns a send command plus a 32-bit payload stream into one header flit
// followed by LEN payload flits on a registered ready/valid initiator port.
// Self-addressed commands are rejected (err_self pulse) and their payload is
// drained so the payload source never deadlocks.
// Optional feature macro: FWNOC_HOST_TX_CRC_EN appends one XOR trailer flit.
module fwnoc_host_tx #(
  parameter int X_ID  = 0,
  parameter int Y_ID  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_dst_x,
  input  logic [3:0]       cmd_dst_y,
  input  logic [7:0]       cmd_len,
  input  logic [7:0]       cmd_tag,
  input  logic [31:0]      pd_dat,
  input  logic             pd_valid,
  output logic             pd_ready,
  output logic [31:0]      o_dat,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             busy,
  output logic             err_self,
  output logic [CNT_W-1:0] pkt_cnt
);

  localparam logic [3:0] SRC_X = 4'(X_ID);
  localparam logic [3:0] SRC_Y = 4'(Y_ID);

  // S_HDR is a reserved encoding: the header is loaded straight out of IDLE.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_PAY   = 3'd2,
    S_DRAIN = 3'd3
`ifdef FWNOC_HOST_TX_CRC_EN
    , S_TRL = 3'd4
`endif
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_rem;
  logic [7:0]         w_rem_nxt;
  logic [31:0]        r_dat;
  logic               r_valid;
  logic               r_last;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_adv;
  logic               w_self;
  logic [31:0]        w_hdr;
  logic               w_load;
  logic [31:0]        w_load_dat;
  logic               w_load_last;
  logic               w_err_nxt;
  logic               w_cmd_ready;
  logic               w_pd_ready;
`ifdef FWNOC_HOST_TX_CRC_EN
  logic [31:0]        r_crc;
  logic [31:0]        w_crc_nxt;
`endif

  assign w_adv  = !r_valid || o_ready;
  assign w_self = (cmd_dst_x == SRC_X) && (cmd_dst_y == SRC_Y);
  assign w_hdr  = {cmd_dst_x, cmd_dst_y, SRC_X, SRC_Y, cmd_len, cmd_tag};

  // Next-state, output-register load selection and handshake readies.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_load      = 1'b0;
    w_load_dat  = r_dat;
    w_load_last = 1'b0;
    w_err_nxt   = 1'b0;
    w_cmd_ready = 1'b0;
    w_pd_ready  = 1'b0;
`ifdef FWNOC_HOST_TX_CRC_EN
    w_crc_nxt   = r_crc;
`endif
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = w_adv;
        if (cmd_valid && w_adv) begin
          if (w_self) begin
            w_err_nxt = 1'b1;
            w_rem_nxt = cmd_len;
            if (cmd_len != 8'd0) begin
              w_state_nxt = S_DRAIN;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_load     = 1'b1;
            w_load_dat = w_hdr;
            w_rem_nxt  = cmd_len;
`ifdef FWNOC_HOST_TX_CRC_EN
            w_crc_nxt  = w_hdr;
`endif
            if (cmd_len == 8'd0) begin
`ifdef FWNOC_HOST_TX_CRC_EN
              w_state_nxt = S_TRL;
              w_load_last = 1'b0;
`else
              w_state_nxt = S_IDLE;
              w_load_last = 1'b1;
`endif
            end else begin
              w_state_nxt = S_PAY;
              w_load_last = 1'b0;
            end
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PAY: begin
        w_pd_ready = w_adv;
        if (pd_valid && w_adv) begin
          w_load     = 1'b1;
          w_load_dat = pd_dat;
          w_rem_nxt  = r_rem - 8'd1;
`ifdef FWNOC_HOST_TX_CRC_EN
          w_crc_nxt  = r_crc ^ pd_dat;
`endif
          if (r_rem == 8'd1) begin
`ifdef FWNOC_HOST_TX_CRC_EN
            w_state_nxt = S_TRL;
            w_load_last = 1'b0;
`else
            w_state_nxt = S_IDLE;
            w_load_last = 1'b1;
`endif
          end else begin
            w_state_nxt = S_PAY;
          end
        end else begin
          w_state_nxt = S_PAY;
        end
      end
      S_DRAIN: begin
        // Discarded words never touch the output register, so no stall here.
        w_pd_ready = 1'b1;
        if (pd_valid) begin
          w_rem_nxt = r_rem - 8'd1;
          if (r_rem == 8'd1) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
`ifdef FWNOC_HOST_TX_CRC_EN
      S_TRL: begin
        if (w_adv) begin
          w_load      = 1'b1;
          w_load_dat  = r_crc;
          w_load_last = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_TRL;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, output flit register, error pulse and sent-packet counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rem   <= 8'd0;
      r_dat   <= 32'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
`ifdef FWNOC_HOST_TX_CRC_EN
      r_crc   <= 32'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_err   <= w_err_nxt;
`ifdef FWNOC_HOST_TX_CRC_EN
      r_crc   <= w_crc_nxt;
`endif
      if (w_adv) begin
        r_valid <= w_load;
        if (w_load) begin
          r_dat  <= w_load_dat;
          r_last <= w_load_last;
        end
      end
      if (r_valid && o_ready && r_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Readies are held low while reset is asserted so nothing handshakes then.
  assign cmd_ready = w_cmd_ready && !reset;
  assign pd_ready  = w_pd_ready && !reset;
  assign o_dat     = r_dat;
  assign o_valid   = r_valid;
  assign busy      = (r_state != S_IDLE) || r_valid;
  assign err_self  = r_err;
  assign pkt_cnt   = r_cnt;

endmodule
